mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
Sequencing controller for the multi-cycle multiply/divide unit (MDU) and the HI/LO registers fed by the ID/EX pipeline register.
- Accepts MDU operations arriving in EX (MDUOpE, MTHILOE), starts the MDU datapath and counts its latency.
- Commits HI/LO at completion.
- Stalls IF/ID and bubbles ID/EX while a later MDU-using instruction waits in decode.
- Sits beside the hazard unit; its stall/flush outputs are ORed into the pipeline-register enable/clear controls.

Parameters:
MULT_CYCLES, 5, total cycles from start pulse to HI/LO commit for MULT/MULTU (>=1)
DIV_CYCLES, 10, total cycles from start pulse to HI/LO commit for DIV/DIVU (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
MDUOpE  in  4  MDU op in EX: MDU_DUM=0 (none), MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4; other codes are treated as MDU_DUM
MTHILOE  in  2  move-to in EX: 01=MTLO, 10=MTHI, 00=none (11 never issued by decoder)
MDUUseD  in  1  instruction in ID uses the MDU (MDUOp!=DUM, MTHILO!=0 or MFHILO!=0)
StartE  out  1  one-cycle start pulse to the MDU datapath (latch operands, begin)
OpSignedE  out  1  signed op at start (MULT/DIV)
Busy  out  1  operation in flight
HiWrite  out  1  write HI this cycle
LoWrite  out  1  write LO this cycle
HiLoSrc  out  2  HI/LO write source: 00=mult result, 01=div result, 10=GPR (move-to)
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushE  out  1  clear ID/EX (insert bubble)

Behaviour:
- States: IDLE, MULT, DIV. Down-counter cnt[CNT_W-1:0].
- Reset: state=IDLE, cnt=0. All outputs 0 in the cycle after reset; no HI/LO write.
- IDLE, MDUOpE!=DUM:
  - StartE=1 combinationally in the same cycle.
  - OpSignedE=1 for MULT/DIV, 0 for MULTU/DIVU.
  - Next state MULT (cnt<=MULT_CYCLES-1) or DIV (cnt<=DIV_CYCLES-1).
- IDLE, MDUOpE==DUM, MTHILOE!=0:
  - HiWrite=MTHILOE[1], LoWrite=MTHILOE[0], HiLoSrc=10, same cycle. Stays IDLE.
- IDLE with both MDUOpE and MTHILOE nonzero: the MDU op wins and the move-to is ignored. The decoder never issues this.
- MULT/DIV:
  - Busy=1.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: Done cycle. HiWrite=LoWrite=1, HiLoSrc=00 (MULT) or 01 (DIV), next state IDLE.
- Latency: start at cycle t, commit (Done) at cycle t+N, where N=MULT_CYCLES or DIV_CYCLES. The next op may start at t+N+1.
- Hazard: StallF=StallD=FlushE = MDUUseD & (StartE | (Busy & ~Done)).
  - In the Done cycle the stall releases. The waiting instruction enters EX at t+N+1 and sees committed HI/LO.
  - Non-MDU instructions never stall and overlap freely with a running op.
- MDUOpE/MTHILOE arriving while Busy cannot occur (stalled in D). If it does, it is ignored: no restart, no write.
- Division by zero is not special-cased: still DIV_CYCLES, and the commit still happens.
- Reset mid-operation: state returns to IDLE, the in-flight op is abandoned, and no HiWrite/LoWrite is issued.
- HiLoSrc=00 whenever no write is asserted.

Decomposition:
- Shared macro header (macro.vh): MDU_DUM/MULT/MULTU/DIV/DIVU op codes, MTHILO/HiLoSrc encodings, state encodings.
- One natural sub-module, mdu_latency_cnt: loadable down-counter with a zero flag. The FSM, write decode and hazard logic stay in mdu_sched.

Test Plan:
- MULT in EX at t, MDUUseD=0 throughout -> StartE=1, OpSignedE=1 at t; Busy=1 t+1..t+5; HiWrite=LoWrite=1, HiLoSrc=00 at t+5; Busy=0 at t+6.
- DIVU at t, then MFLO in ID (MDUUseD=1) from t -> StallF/StallD/FlushE=1 for t..t+9, 0 at t+10 (Done, HiLoSrc=01, OpSignedE=0 at t), MFLO in EX at t+11.
- MTHI in EX while IDLE (MTHILOE=10) -> HiWrite=1, LoWrite=0, HiLoSrc=10 same cycle, Busy stays 0, no stall.
- Back-to-back MULT, MULTU with MULTU in ID -> stall until t+5; MULTU StartE at t+6; second commit at t+11.
- reset=1 at t+3 of a DIV -> Busy=0 at t+4, no HiWrite/LoWrite at t+10; a new MULT at t+5 completes normally at t+10.
- Illegal MDUOpE=4'hF in IDLE -> no StartE, no write, no stall.

Source files
------------

// File: rtl/mdu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched_pkg
// Description : Shared encodings for the MDU sequencing controller: EX-stage
//               op codes, move-to codes, HI/LO write sources, FSM states.
//               Op code 0 (and every code above 4) means "no MDU op".
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_sched_pkg;

  // MDU op codes carried in MDUOpE
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;

  // Move-to code carried in MTHILOE (bit1 = HI, bit0 = LO)
  localparam logic [1:0] MTHILO_NONE = 2'b00;

  // HI/LO write source select
  localparam logic [1:0] HILO_SRC_MULT = 2'b00;
  localparam logic [1:0] HILO_SRC_DIV  = 2'b01;
  localparam logic [1:0] HILO_SRC_GPR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // Any code outside MULT..DIVU is treated as "no op"
  function automatic logic isMduOp(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_latency_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mdu_latency_cnt
// Description : Loadable down-counter with a zero flag, used to time the
//               multi-cycle MDU latency. Holds at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_latency_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; never wrap below zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= loadVal;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched
// Description : Sequencing controller for the multi-cycle multiply/divide
//               unit. Starts the datapath, times its latency, commits HI/LO
//               on completion, handles move-to-HI/LO, and stalls decode
//               while an MDU-using instruction waits behind a running op.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] MDUOpE,
  input  logic [1:0] MTHILOE,
  input  logic       MDUUseD,
  output logic       StartE,
  output logic       OpSignedE,
  output logic       Busy,
  output logic       HiWrite,
  output logic       LoWrite,
  output logic [1:0] HiLoSrc,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE
);

  // Counter load values: start cycle is t, Done cycle is t+N
  localparam logic [CNT_W-1:0] c_multLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_divLoad  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       r_state;
  mdu_state_e       w_stateNext;
  logic             w_load;
  logic [CNT_W-1:0] w_loadVal;
  logic             w_dec;
  logic             w_cntZero;
  logic             w_done;
  logic             w_hazard;

  mdu_latency_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .loadVal (w_loadVal),
    .dec     (w_dec),
    .zero    (w_cntZero)
  );

  // State register; reset abandons any in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state, start/commit decode and counter control
  always_comb begin
    w_stateNext = r_state;
    StartE      = 1'b0;
    OpSignedE   = 1'b0;
    Busy        = 1'b0;
    HiWrite     = 1'b0;
    LoWrite     = 1'b0;
    HiLoSrc     = HILO_SRC_MULT;
    w_load      = 1'b0;
    w_loadVal   = '0;
    w_dec       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An MDU op wins over a simultaneous move-to
        if (isMduOp(MDUOpE)) begin
          StartE    = 1'b1;
          OpSignedE = isSignedOp(MDUOpE);
          w_load    = 1'b1;
          if (isDivOp(MDUOpE)) begin
            w_stateNext = ST_DIV;
            w_loadVal   = c_divLoad;
          end else begin
            w_stateNext = ST_MULT;
            w_loadVal   = c_multLoad;
          end
        end else if (MTHILOE != MTHILO_NONE) begin
          HiWrite = MTHILOE[1];
          LoWrite = MTHILOE[0];
          HiLoSrc = HILO_SRC_GPR;
        end
      end
      ST_MULT, ST_DIV: begin
        // New EX requests while busy are ignored
        Busy = 1'b1;
        if (w_cntZero) begin
          w_done      = 1'b1;
          HiWrite     = 1'b1;
          LoWrite     = 1'b1;
          HiLoSrc     = (r_state == ST_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
          w_stateNext = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Stall releases in the Done cycle so the waiter sees committed HI/LO
  assign w_hazard = MDUUseD & (StartE | (Busy & ~w_done));
  assign StallF   = w_hazard;
  assign StallD   = w_hazard;
  assign FlushE   = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sched
// Description : Self-checking bench for mdu_sched with a timestamp-based
//               reference model (op start cycle + latency = commit cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] MDUOpE = 4'd0;
  logic [1:0] MTHILOE = 2'd0;
  logic       MDUUseD = 1'b0;
  logic       StartE, OpSignedE, Busy, HiWrite, LoWrite, StallF, StallD, FlushE;
  logic [1:0] HiLoSrc;

  mdu_sched #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MDUOpE    (MDUOpE),
    .MTHILOE   (MTHILOE),
    .MDUUseD   (MDUUseD),
    .StartE    (StartE),
    .OpSignedE (OpSignedE),
    .Busy      (Busy),
    .HiWrite   (HiWrite),
    .LoWrite   (LoWrite),
    .HiLoSrc   (HiLoSrc),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE)
  );

  always #5 clk = ~clk;

  // {StartE, OpSignedE, Busy, HiWrite, LoWrite, HiLoSrc[1:0], StallF, StallD, FlushE}
  logic [9:0] obs;
  logic [9:0] expv;
  assign obs = {StartE, OpSignedE, Busy, HiWrite, LoWrite, HiLoSrc, StallF, StallD, FlushE};

  int checks = 0;
  int errors = 0;

  // Reference model: an op accepted at cycle s commits at cycle s+N
  int cyc = 0;
  bit known = 1'b0;
  bit active = 1'b0;
  bit opIsDiv = 1'b0;
  int commitCyc = 0;

  function automatic bit legalOp(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  task automatic modelOutputs();
    bit st, sg, hw, lw, dn, stall;
    logic [1:0] src;
    dn = active && (cyc == commitCyc);
    st = !active && legalOp(MDUOpE);
    sg = st && (MDUOpE == 4'd1 || MDUOpE == 4'd3);
    hw = 1'b0; lw = 1'b0; src = 2'b00;
    if (dn) begin
      hw = 1'b1; lw = 1'b1; src = opIsDiv ? 2'b01 : 2'b00;
    end else if (!active && !legalOp(MDUOpE) && MTHILOE != 2'b00) begin
      hw = MTHILOE[1]; lw = MTHILOE[0]; src = 2'b10;
    end
    stall = MDUUseD && (st || (active && !dn));
    expv = {st, sg, active, hw, lw, src, stall, stall, stall};
  endtask

  task automatic modelEdge();
    bit st, dn;
    dn = active && (cyc == commitCyc);
    st = !active && legalOp(MDUOpE);
    if (reset) begin
      active = 1'b0;
      known  = 1'b1;
    end else if (known && st) begin
      active    = 1'b1;
      opIsDiv   = (MDUOpE == 4'd3 || MDUOpE == 4'd4);
      commitCyc = cyc + (opIsDiv ? DIV_CYCLES : MULT_CYCLES);
    end else if (known && dn) begin
      active = 1'b0;
    end
    cyc++;
  endtask

  // Advance one clock, drive this cycle's inputs, compute the expectation
  task automatic cycle(input logic [3:0] op, input logic [1:0] mt,
                       input logic useD, input logic rst);
    @(posedge clk);
    modelEdge();
    #1;
    MDUOpE = op; MTHILOE = mt; MDUUseD = useD; reset = rst;
    #2;
    modelOutputs();
  endtask

  task automatic test_reset();
    cycle(4'd0, 2'd0, 1'b0, 1'b1);
    cycle(4'd1, 2'd0, 1'b1, 1'b1);
    cycle(4'd0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, obs, 10'b0);
    end
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
    end
  endtask

  task automatic test_mult();
    int doneAt;
    doneAt = -1;
    cycle(4'd1, 2'd0, 1'b0, 1'b0);
    checks++;
    if (obs[9:8] !== 2'b11 || obs[2:0] !== 3'b000) begin
      errors++; $display("FAIL mult_start cyc=%0d got=%b exp=11xxxxx000", cyc, obs);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(4'd0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL mult_seq k=%0d got=%b exp=%b", k, obs, expv);
      end
      if (obs[6:5] === 2'b11 && doneAt < 0) doneAt = k;
    end
    checks++;
    if (doneAt !== MULT_CYCLES) begin
      errors++; $display("FAIL mult_latency got=%0d exp=%0d", doneAt, MULT_CYCLES);
    end
  endtask

  task automatic test_divu_stall();
    int stalls;
    stalls = 0;
    cycle(4'd4, 2'd0, 1'b1, 1'b0);
    checks++;
    if (obs !== expv || obs[8] !== 1'b0) begin
      errors++; $display("FAIL divu_start got=%b exp=%b", obs, expv);
    end
    if (obs[2]) stalls++;
    for (int k = 1; k <= 13; k++) begin
      cycle(4'd0, 2'd0, (k <= 10) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL divu_seq k=%0d got=%b exp=%b", k, obs, expv);
      end
      if (obs[2]) stalls++;
    end
    checks++;
    if (stalls !== DIV_CYCLES) begin
      errors++; $display("FAIL divu_stall_len got=%0d exp=%0d", stalls, DIV_CYCLES);
    end
  endtask

  task automatic test_mthi();
    cycle(4'd0, 2'b10, 1'b1, 1'b0);
    checks++;
    if (obs !== 10'b0001010000) begin
      errors++; $display("FAIL mthi got=%b exp=%b", obs, 10'b0001010000);
    end
    cycle(4'd0, 2'b01, 1'b0, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL mtlo got=%b exp=%b", obs, expv);
    end
    cycle(4'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int secondDone;
    secondDone = -1;
    cycle(4'd1, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      cycle((k == 6) ? 4'd2 : 4'd0, 2'd0, (k <= 5) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL b2b_seq k=%0d got=%b exp=%b", k, obs, expv);
      end
      if (k > 6 && obs[6:5] === 2'b11 && secondDone < 0) secondDone = k;
    end
    checks++;
    if (secondDone !== 11) begin
      errors++; $display("FAIL b2b_second_commit got=%0d exp=%0d", secondDone, 11);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    writes = 0;
    cycle(4'd3, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle((k == 5) ? 4'd1 : 4'd0, 2'd0, 1'b0, (k == 3) ? 1'b1 : 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL rstmid_seq k=%0d got=%b exp=%b", k, obs, expv);
      end
      if (k == 4) begin
        checks++;
        if (obs[7] !== 1'b0) begin
          errors++; $display("FAIL rstmid_busy got=%b exp=0", obs[7]);
        end
      end
      if (obs[6] === 1'b1 || obs[5] === 1'b1) begin
        writes++;
        checks++;
        if (k != 10 || obs[4:3] !== 2'b00) begin
          errors++; $display("FAIL rstmid_write k=%0d got=%b exp=k10_src00", k, obs);
        end
      end
    end
    checks++;
    if (writes !== 1) begin
      errors++; $display("FAIL rstmid_write_count got=%0d exp=1", writes);
    end
  endtask

  task automatic test_illegal();
    cycle(4'hF, 2'd0, 1'b1, 1'b0);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL illegal_op got=%b exp=%b", obs, 10'b0);
    end
    cycle(4'd0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL illegal_after got=%b exp=%b", obs, 10'b0);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [1:0] mt;
    int r;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      op = 4'd0;
      else if (r < 9) op = 4'($urandom_range(1, 4));
      else            op = 4'($urandom_range(5, 15));
      mt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle(op, mt, 1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random k=%0d op=%h mt=%b got=%b exp=%b", k, op, mt, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_mthi();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
